// File: rtl/uart_rx_port_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// default line parameters and the baud divider calculation.
package uart_rx_port_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_t;

   localparam int DEF_CLK_HZ     = 100_000_000;
   localparam int DEF_BAUD       = 115_200;
   localparam int DEF_OVERSAMPLE = 16;

   // Clocks per oversample tick, rounded to nearest.
   function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
      int den;
      den = baud * oversample;
      return (clk_hz + den / 2) / den;
   endfunction

endpackage

// File: rtl/uart_rx_port_baud_tick_gen.sv
// Oversample tick generator. One-cycle o_tick every DIV clocks while i_en
// is high; the counter sits at 0 while disabled so the first tick lands a
// full DIV clocks after enable.
module baud_tick_gen #(
   parameter int DIV = 54
) (
   input  logic SYS_CLK,
   input  logic SYS_RST,
   input  logic i_en,
   output logic o_tick
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] TERM   = (DIV > 1) ? CNT_W'(1) : '0;

   logic [CNT_W-1:0] cnt;

   // Down-counter: 0 -> reload -> ... -> 1 (terminal) -> 0, DIV states per period.
   always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
      if (!SYS_RST) begin
         cnt <= '0;
      end else if (!i_en) begin
         cnt <= '0;
      end else if (cnt == '0) begin
         cnt <= RELOAD;
      end else begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign o_tick = i_en && (cnt == TERM);

endmodule

// File: rtl/uart_rx_port.sv
// 8N1 serial receiver feeding a polled one-deep holding register.
//
// state    | meaning
// ST_IDLE  | line idle, waiting for a falling edge on rx_s
// ST_START | start bit seen, confirm it is still low at mid-bit
// ST_DATA  | shifting in 8 data bits, LSB first, one per bit period
// ST_STOP  | sampling the stop bit; high accepts the byte, low is a frame error
module uart_rx_port
   import uart_rx_port_pkg::*;
#(
   parameter int CLK_HZ     = DEF_CLK_HZ,
   parameter int BAUD       = DEF_BAUD,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic       SYS_CLK,
   input  logic       SYS_RST,
   input  logic       i_RX,
   input  logic       i_rd,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_frame_err,
   output logic       o_overrun
);

   localparam int DIV    = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
   localparam int SCNT_W = $clog2(OVERSAMPLE);
   localparam logic [SCNT_W-1:0] MID  = SCNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [SCNT_W-1:0] LAST = SCNT_W'(OVERSAMPLE - 1);

   logic              rx_meta, rx_s, rx_s_d;
   logic              rx_fall;
   logic              tick;
   rx_state_t         state;
   logic [SCNT_W-1:0] sample_cnt;
   logic [2:0]        bit_cnt;
   logic [7:0]        shift_reg;
   logic              byte_done;
   logic              stop_sample;
   logic              frame_err_set;

   // Two-flop synchronizer plus one delay stage for falling-edge detection.
   always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
      if (!SYS_RST) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_s_d  <= 1'b1;
      end else begin
         rx_meta <= i_RX;
         rx_s    <= rx_meta;
         rx_s_d  <= rx_s;
      end
   end

   // An edge, not a low level, arms reception so a held break reports once.
   assign rx_fall = rx_s_d && !rx_s;

   baud_tick_gen #(.DIV(DIV)) u_tick (
      .SYS_CLK (SYS_CLK),
      .SYS_RST (SYS_RST),
      .i_en    (state != ST_IDLE),
      .o_tick  (tick)
   );

   assign stop_sample   = (state == ST_STOP) && tick && (sample_cnt == LAST);
   assign frame_err_set = stop_sample && !rx_s;

   // Deframing FSM; byte_done pulses the cycle after a good stop bit.
   always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
      if (!SYS_RST) begin
         state      <= ST_IDLE;
         sample_cnt <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         byte_done  <= 1'b0;
      end else begin
         byte_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rx_fall) begin
                  state      <= ST_START;
                  sample_cnt <= '0;
               end
            end
            ST_START: begin
               if (tick) begin
                  if (sample_cnt == MID) begin
                     sample_cnt <= '0;
                     bit_cnt    <= '0;
                     state      <= rx_s ? ST_IDLE : ST_DATA;
                  end else begin
                     sample_cnt <= sample_cnt + SCNT_W'(1);
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (sample_cnt == LAST) begin
                     sample_cnt <= '0;
                     shift_reg  <= {rx_s, shift_reg[7:1]};
                     bit_cnt    <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        state <= ST_STOP;
                     end
                  end else begin
                     sample_cnt <= sample_cnt + SCNT_W'(1);
                  end
               end
            end
            ST_STOP: begin
               if (tick) begin
                  if (sample_cnt == LAST) begin
                     sample_cnt <= '0;
                     byte_done  <= rx_s;
                     state      <= ST_IDLE;
                  end else begin
                     sample_cnt <= sample_cnt + SCNT_W'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Holding register and sticky flags; a read in the acceptance cycle lets
   // the new byte replace the old one without an overrun.
   always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
      if (!SYS_RST) begin
         o_data      <= 8'h00;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         if (byte_done) begin
            if (!o_valid || i_rd) begin
               o_data  <= shift_reg;
               o_valid <= 1'b1;
            end
         end else if (i_rd) begin
            o_valid <= 1'b0;
         end

         if (byte_done && o_valid && !i_rd) begin
            o_overrun <= 1'b1;
         end else if (i_rd) begin
            o_overrun <= 1'b0;
         end

         if (frame_err_set) begin
            o_frame_err <= 1'b1;
         end else if (i_rd) begin
            o_frame_err <= 1'b0;
         end
      end
   end

endmodule
